// File: rtl/gb_host_arb_if.sv
// Bundles the two host request/response ports and the shared bus of gb_host_arb.
// master = arbiter side, slave = host and bus environment side.
interface gb_host_arb_if #(
   parameter int AW = 24,
   parameter int DW = 32
);
   logic          req0_valid;
   logic          req0_ready;
   logic          req0_we;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic          rsp0_valid;
   logic [DW-1:0] rsp0_rdata;

   logic          req1_valid;
   logic          req1_ready;
   logic          req1_we;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic          rsp1_valid;
   logic [DW-1:0] rsp1_rdata;

   logic [AW-1:0] gb_addr;
   logic [DW-1:0] gb_wdata;
   logic          gb_we;
   logic          gb_re;
   logic [DW-1:0] gb_rdata;

   modport master (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      input  gb_rdata,
      output req0_ready, rsp0_valid, rsp0_rdata,
      output req1_ready, rsp1_valid, rsp1_rdata,
      output gb_addr, gb_wdata, gb_we, gb_re
   );

   modport slave (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      output gb_rdata,
      input  req0_ready, rsp0_valid, rsp0_rdata,
      input  req1_ready, rsp1_valid, rsp1_rdata,
      input  gb_addr, gb_wdata, gb_we, gb_re
   );
endinterface

// File: rtl/gb_host_arb.sv
// Two-host arbiter onto a single shared bus; one transaction in flight,
// round-robin on ties, read data returned RD_LAT cycles after the read strobe.
module gb_host_arb #(
   parameter int AW     = 24,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input logic           clk,
   input logic           rst,
   gb_host_arb_if.master bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [3:0] LAT = 4'(RD_LAT);

   state_t        state_r, state_s;
   logic          last_grant_r, port_r, we_r;
   logic [3:0]    cnt_r;
   logic          grant0_s, grant1_s, ready0_s, ready1_s, accept_s;
   logic          sel_we_s;
   logic [AW-1:0] sel_addr_s;
   logic [DW-1:0] sel_wdata_s;
   logic          fire_s;
   logic [DW-1:0] fire_data_s;
   logic          gb_we_r, gb_re_r;
   logic [AW-1:0] gb_addr_r;
   logic [DW-1:0] gb_wdata_r;
   logic          rsp0_valid_r, rsp1_valid_r;
   logic [DW-1:0] rsp0_rdata_r, rsp1_rdata_r;

   // Grant: a lone requester wins, on a tie the port not served last wins
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         if (last_grant_r) begin
            grant0_s = 1'b1;
         end else begin
            grant1_s = 1'b1;
         end
      end else if (bus.req0_valid) begin
         grant0_s = 1'b1;
      end else if (bus.req1_valid) begin
         grant1_s = 1'b1;
      end else begin
         grant0_s = 1'b0;
      end
   end

   assign ready0_s = (state_r == ST_IDLE) & grant0_s & ~rst;
   assign ready1_s = (state_r == ST_IDLE) & grant1_s & ~rst;
   assign accept_s = ready0_s | ready1_s;

   // Request fields of whichever port is being accepted
   always_comb begin
      sel_we_s    = bus.req0_we;
      sel_addr_s  = bus.req0_addr;
      sel_wdata_s = bus.req0_wdata;
      if (ready1_s) begin
         sel_we_s    = bus.req1_we;
         sel_addr_s  = bus.req1_addr;
         sel_wdata_s = bus.req1_wdata;
      end else begin
         sel_we_s    = bus.req0_we;
      end
   end

   // Completion: writes finish right after the strobe, reads once the latency count is reached
   always_comb begin
      fire_s      = 1'b0;
      fire_data_s = '0;
      if (state_r == ST_ISSUE && we_r) begin
         fire_s = 1'b1;
      end else if (state_r == ST_WAIT && cnt_r == LAT) begin
         fire_s      = 1'b1;
         fire_data_s = bus.gb_rdata;
      end else begin
         fire_s = 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:  state_s = accept_s ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: state_s = we_r ? ST_RESP : ST_WAIT;
         ST_WAIT:  state_s = fire_s ? ST_RESP : ST_WAIT;
         ST_RESP:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Transaction latch, bus strobes, latency counter and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_r <= 1'b1;
         port_r       <= 1'b0;
         we_r         <= 1'b0;
         cnt_r        <= 4'd0;
         gb_we_r      <= 1'b0;
         gb_re_r      <= 1'b0;
         gb_addr_r    <= '0;
         gb_wdata_r   <= '0;
         rsp0_valid_r <= 1'b0;
         rsp1_valid_r <= 1'b0;
         rsp0_rdata_r <= '0;
         rsp1_rdata_r <= '0;
      end else begin
         gb_we_r      <= 1'b0;
         gb_re_r      <= 1'b0;
         rsp0_valid_r <= 1'b0;
         rsp1_valid_r <= 1'b0;
         if (accept_s) begin
            port_r       <= ready1_s;
            last_grant_r <= ready1_s;
            we_r         <= sel_we_s;
            gb_addr_r    <= sel_addr_s;
            gb_we_r      <= sel_we_s;
            gb_re_r      <= ~sel_we_s;
            if (sel_we_s) begin
               gb_wdata_r <= sel_wdata_s;
            end
         end
         if (state_r == ST_ISSUE) begin
            cnt_r <= 4'd1;
         end else if (state_r == ST_WAIT && !fire_s) begin
            cnt_r <= cnt_r + 4'd1;
         end else begin
            cnt_r <= 4'd0;
         end
         if (fire_s) begin
            if (port_r) begin
               rsp1_valid_r <= 1'b1;
               rsp1_rdata_r <= fire_data_s;
            end else begin
               rsp0_valid_r <= 1'b1;
               rsp0_rdata_r <= fire_data_s;
            end
         end
      end
   end

   assign bus.req0_ready = ready0_s;
   assign bus.req1_ready = ready1_s;
   assign bus.gb_we      = gb_we_r;
   assign bus.gb_re      = gb_re_r;
   assign bus.gb_addr    = gb_addr_r;
   assign bus.gb_wdata   = gb_wdata_r;
   assign bus.rsp0_valid = rsp0_valid_r;
   assign bus.rsp1_valid = rsp1_valid_r;
   assign bus.rsp0_rdata = rsp0_rdata_r;
   assign bus.rsp1_rdata = rsp1_rdata_r;
endmodule

// File: tb/tb_gb_host_arb.sv
// Randomized bench for gb_host_arb against a cycle-schedule reference model
// and a memory-backed bus model.
module tb_gb_host_arb;
   localparam int AW     = 24;
   localparam int DW     = 32;
   localparam int RD_LAT = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gb_host_arb_if #(.AW(AW), .DW(DW)) bus ();
   gb_host_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;

   // host stimulus
   bit            s_v[2];
   bit            s_we[2];
   logic [AW-1:0] s_addr[2];
   logic [DW-1:0] s_wdata[2];

   // reference model: a transaction is a schedule of absolute cycle numbers
   int            cyc = 0;
   int            m_free = 0, m_strobe = -100, m_rsp = -100;
   bit            m_last = 1'b1, m_port, m_we, m_acc;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [DW-1:0] model_mem[64];

   // bus model
   logic [DW-1:0] bus_mem[64];
   int            rd_due = -100;
   logic [DW-1:0] rd_val;

   bit dut_acc, dut_port, prev_port, have_prev;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic drive_inputs();
      bus.req0_valid = s_v[0];  bus.req0_we = s_we[0];
      bus.req0_addr  = s_addr[0]; bus.req0_wdata = s_wdata[0];
      bus.req1_valid = s_v[1];  bus.req1_we = s_we[1];
      bus.req1_addr  = s_addr[1]; bus.req1_wdata = s_wdata[1];
      bus.gb_rdata   = (cyc == rd_due) ? rd_val : DW'($urandom());
   endtask

   task automatic step();
      bit g0, g1, busy, p;
      @(negedge clk);
      drive_inputs();
      #1;
      m_acc = 1'b0;
      dut_acc = 1'b0;
      if (rst) begin
         check_val("rst_ready0", bus.req0_ready, 0);
         check_val("rst_ready1", bus.req1_ready, 0);
         check_val("rst_rsp0", bus.rsp0_valid, 0);
         check_val("rst_rsp1", bus.rsp1_valid, 0);
         check_val("rst_rdata", {bus.rsp1_rdata, bus.rsp0_rdata}, 0);
         check_val("rst_strobe", {bus.gb_we, bus.gb_re}, 0);
         check_val("rst_addr", bus.gb_addr, 0);
         check_val("rst_wdata", bus.gb_wdata, 0);
         m_free = 0; m_strobe = -100; m_rsp = -100; m_last = 1'b1; rd_due = -100;
      end else begin
         busy = (cyc < m_free);
         g0 = !busy && s_v[0] && (!s_v[1] || m_last);
         g1 = !busy && s_v[1] && (!s_v[0] || !m_last);
         check_val("ready0", bus.req0_ready, g0);
         check_val("ready1", bus.req1_ready, g1);
         check_val("gb_we", bus.gb_we, (cyc == m_strobe) && m_we);
         check_val("gb_re", bus.gb_re, (cyc == m_strobe) && !m_we);
         check_val("we_re_excl", bus.gb_we & bus.gb_re, 0);
         if (cyc == m_strobe) begin
            check_val("gb_addr", bus.gb_addr, m_addr);
            if (m_we) check_val("gb_wdata", bus.gb_wdata, m_wdata);
         end
         check_val("rsp0_valid", bus.rsp0_valid, (cyc == m_rsp) && !m_port);
         check_val("rsp1_valid", bus.rsp1_valid, (cyc == m_rsp) && m_port);
         if (cyc == m_rsp) begin
            if (m_port) check_val("rsp1_rdata", bus.rsp1_rdata, m_rdata);
            else        check_val("rsp0_rdata", bus.rsp0_rdata, m_rdata);
         end
         if (bus.gb_we === 1'b1) bus_mem[bus.gb_addr[5:0]] = bus.gb_wdata;
         if (bus.gb_re === 1'b1) begin
            rd_due = cyc + RD_LAT;
            rd_val = bus_mem[bus.gb_addr[5:0]];
         end
         dut_acc  = (bus.req0_ready && bus.req0_valid) || (bus.req1_ready && bus.req1_valid);
         dut_port = bus.req1_ready && bus.req1_valid;
         if (g0 || g1) begin
            p        = g1;
            m_acc    = 1'b1;
            m_port   = p;
            m_last   = p;
            m_we     = s_we[p];
            m_addr   = s_addr[p];
            m_wdata  = s_wdata[p];
            m_strobe = cyc + 1;
            m_rsp    = m_we ? cyc + 2 : cyc + 2 + RD_LAT;
            m_free   = m_rsp + 1;
            m_rdata  = m_we ? '0 : model_mem[m_addr[5:0]];
            if (m_we) model_mem[m_addr[5:0]] = m_wdata;
         end
      end
      cyc++;
   endtask

   task automatic drain();
      while (cyc < m_free) step();
   endtask

   task automatic send(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int k = 0;
      s_v[p] = 1'b1; s_we[p] = we; s_addr[p] = a; s_wdata[p] = d;
      do begin
         step();
         k++;
      end while (!m_acc && k < 20);
      if (!m_acc) begin
         n_checks++;
         $display("FAIL accept_timeout: port %0d not accepted within 20 cycles", p);
      end
      s_v[p] = 1'b0;
      drain();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         model_mem[i] = '0;
         bus_mem[i]   = '0;
      end
      for (int i = 0; i < 2; i++) begin
         s_v[i] = 1'b1; s_we[i] = 1'b1; s_addr[i] = '0; s_wdata[i] = '0;
      end
      rst = 1'b1;
      drive_inputs();
      repeat (2) step();
      s_v[0] = 1'b0; s_v[1] = 1'b0;
      step();
      rst = 1'b0;
      step();

      // port0 write, then port1 read with a known bus word
      send(0, 1'b1, 24'h10, 32'hA5);
      bus_mem[32]   = 32'hDEAD;
      model_mem[32] = 32'hDEAD;
      send(1, 1'b0, 24'h20, 32'h0);

      // both ports saturating: accepts must alternate
      have_prev = 1'b0;
      s_v[0] = 1'b1; s_v[1] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         for (int j = 0; j < 2; j++) begin
            s_we[j] = 1'($urandom()); s_addr[j] = AW'($urandom_range(0, 7)); s_wdata[j] = $urandom();
         end
         step();
         if (dut_acc) begin
            if (have_prev) check_val("alternate", dut_port, !prev_port);
            prev_port = dut_port;
            have_prev = 1'b1;
         end
      end
      s_v[0] = 1'b0; s_v[1] = 1'b0;
      drain();

      // port1 alone for four transactions
      for (int i = 0; i < 4; i++) send(1, 1'($urandom()), AW'($urandom_range(0, 7)), $urandom());

      // reset while a read is waiting for bus data
      s_v[0] = 1'b1; s_we[0] = 1'b0; s_addr[0] = 24'h3;
      for (int k = 0; k < 20 && !m_acc; k++) step();
      s_v[0] = 1'b0;
      step();
      step();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      s_v[0] = 1'b1; s_v[1] = 1'b1; s_we[0] = 1'b1; s_we[1] = 1'b1;
      step();
      check_val("post_rst_tie", {bus.req1_ready, bus.req0_ready}, 2'b01);
      s_v[0] = 1'b0; s_v[1] = 1'b0;
      drain();

      // random mixed traffic
      for (int i = 0; i < 600; i++) begin
         for (int j = 0; j < 2; j++) begin
            s_v[j] = 1'($urandom()); s_we[j] = 1'($urandom());
            s_addr[j] = AW'($urandom_range(0, 7)); s_wdata[j] = $urandom();
         end
         step();
      end
      s_v[0] = 1'b0; s_v[1] = 1'b0;
      drain();
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/gb_host_arb.md
GB_HOST_ARB -- requirements
Module: gb_host_arb

Interface
REQ-001 Parameter AW, default 24, bus address width in bits.
REQ-002 Parameter DW, default 32, bus data width in bits.
REQ-003 Parameter RD_LAT, default 1, cycles from read strobe to valid gb_rdata; legal range 1..15.
REQ-004 clk  input  1  single clock; all logic SHALL be rising-edge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 reqN_valid  input  1  host N (N=0,1) transaction request.
REQ-007 reqN_ready  output  1  host N request accepted this cycle.
REQ-008 reqN_we  input  1  1 = write, 0 = read.
REQ-009 reqN_addr  input  AW  host N address.
REQ-010 reqN_wdata  input  DW  host N write data.
REQ-011 rspN_valid  output  1  one-cycle completion pulse for host N.
REQ-012 rspN_rdata  output  DW  read data; valid only with rspN_valid.
REQ-013 gb_addr  output  AW  shared bus address.
REQ-014 gb_wdata  output  DW  shared bus write data.
REQ-015 gb_we  output  1  one-cycle write strobe.
REQ-016 gb_re  output  1  one-cycle read strobe.
REQ-017 gb_rdata  input  DW  bus read data, valid RD_LAT cycles after gb_re.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight at any time.
REQ-019 IDLE: reqN_ready SHALL be combinational = (state==IDLE) & grantN & ~rst; outside IDLE both readys SHALL be 0.
REQ-020 Grant: only one valid -> that port; both valid -> port != last_grant; neither -> no grant.
REQ-021 Accept (valid&ready at cycle T): latch we/addr/wdata and port id, set last_grant = port, go ISSUE.
REQ-022 ISSUE (cycle T+1): drive gb_addr/gb_wdata from latch, pulse gb_we (write) or gb_re (read) for exactly one cycle; never both.
REQ-023 Write: ISSUE -> RESP; rspN_valid SHALL pulse at T+2 with rspN_rdata = 0.
REQ-024 Read: ISSUE -> WAIT; 4-bit counter SHALL capture gb_rdata at cycle T+1+RD_LAT, then RESP; rspN_valid at T+2+RD_LAT.
REQ-025 RESP: one-cycle rspN_valid to the latched port only, then IDLE; new accept possible same cycle as return to IDLE (T+3 write min).
REQ-026 No response backpressure; host SHALL accept rsp pulse when issued.
REQ-027 reqN_valid dropping after accept SHALL NOT affect the in-flight transaction.
REQ-028 gb_addr/gb_wdata SHALL hold last driven value between transactions.
REQ-029 Non-granted port's rspN_valid and reqN_ready SHALL remain 0 throughout another port's transaction.

Reset
REQ-030 rst assertion SHALL immediately force state IDLE, last_grant=1 (port 0 wins first tie), counter 0.
REQ-031 Reset values: reqN_ready 0, rspN_valid 0, rspN_rdata 0, gb_we 0, gb_re 0, gb_addr 0, gb_wdata 0.
REQ-032 Reset mid-transaction SHALL abort it with no strobe and no response issued after rst rises.

Verification
REQ-033 Port0 write addr=0x10 wdata=0xA5 at T -> gb_we=1, gb_addr=0x10, gb_wdata=0xA5 at T+1; rsp0_valid at T+2.
REQ-034 RD_LAT=3, port1 read addr=0x20, bus returns 0xDEAD at T+4 -> rsp1_valid, rsp1_rdata=0xDEAD at T+5.
REQ-035 Both valid continuously after reset -> accepts alternate 0,1,0,1; no port accepted twice consecutively.
REQ-036 Only port1 valid for 4 transactions -> port1 granted every time; port0 never ready.
REQ-037 rst asserted during WAIT of a read -> outputs at reset values next sample, no rsp_valid; post-reset tie grants port0.
REQ-038 Random traffic both ports, bus model with memory -> every read returns last written data; gb_we&gb_re never both 1.
